// File: rtl/cdb_arbiter_if.sv
// Writeback requester / CDB broadcast bundle for cdb_arbiter.
// master = FU writeback and CDB consumer side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2,
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ROB_IDX-1:0]  req_rob_id;
  logic [NUM_REQ*PRF_IDX-1:0]  req_pd;
  logic [NUM_REQ*ARF_IDX-1:0]  req_rd;
  logic [NUM_REQ*32-1:0]       req_rd_value;
  logic [NUM_REQ-1:0]          req_regf_we;

  logic [NUM_CDB-1:0]          cdb_valid;
  logic [NUM_CDB*ROB_IDX-1:0]  cdb_rob_id;
  logic [NUM_CDB*PRF_IDX-1:0]  cdb_pd;
  logic [NUM_CDB*ARF_IDX-1:0]  cdb_rd;
  logic [NUM_CDB*32-1:0]       cdb_rd_value;
  logic [NUM_CDB-1:0]          cdb_regf_we;

  modport master (
    output req_valid, req_rob_id, req_pd, req_rd, req_rd_value, req_regf_we,
    input  req_ready,
    input  cdb_valid, cdb_rob_id, cdb_pd, cdb_rd, cdb_rd_value, cdb_regf_we
  );

  modport slave (
    input  req_valid, req_rob_id, req_pd, req_rd, req_rd_value, req_regf_we,
    output req_ready,
    output cdb_valid, cdb_rob_id, cdb_pd, cdb_rd, cdb_rd_value, cdb_regf_we
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Rotating-priority arbiter sharing NUM_CDB broadcast slots among NUM_REQ
// writeback requesters; grants are combinational, broadcasts registered.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2,
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         backend_flush,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLOT_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_CDB-1:0]              slot_vld;
  logic [NUM_CDB-1:0][PTR_W-1:0]   slot_src;
  logic [PTR_W-1:0]                last_win;

  logic [NUM_CDB-1:0]              cdb_valid_q, cdb_valid_d;
  logic [NUM_CDB*ROB_IDX-1:0]      cdb_rob_id_q, cdb_rob_id_d;
  logic [NUM_CDB*PRF_IDX-1:0]      cdb_pd_q, cdb_pd_d;
  logic [NUM_CDB*ARF_IDX-1:0]      cdb_rd_q, cdb_rd_d;
  logic [NUM_CDB*32-1:0]           cdb_rd_value_q, cdb_rd_value_d;
  logic [NUM_CDB-1:0]              cdb_regf_we_q, cdb_regf_we_d;

  // Scan from rr_ptr; the j-th valid requester found lands in slot j.
  always_comb begin : grant_scan
    int idx;
    int cnt;
    grant    = '0;
    slot_vld = '0;
    slot_src = '0;
    last_win = rr_ptr_q;
    idx      = 0;
    cnt      = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = int'(rr_ptr_q) + o;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx] && cnt < NUM_CDB) begin
        grant[idx]                 = 1'b1;
        slot_vld[SLOT_W'(cnt)]     = 1'b1;
        slot_src[SLOT_W'(cnt)]     = PTR_W'(idx);
        last_win                   = PTR_W'(idx);
        cnt                        = cnt + 1;
      end
    end
  end

  // A flush suppresses grants, so nothing accepted during it is ever broadcast.
  assign bus.req_ready = (rst || backend_flush) ? '0 : grant;

  always_comb begin : bcast_next
    int s;
    s              = 0;
    cdb_valid_d    = slot_vld;
    cdb_rob_id_d   = cdb_rob_id_q;
    cdb_pd_d       = cdb_pd_q;
    cdb_rd_d       = cdb_rd_q;
    cdb_rd_value_d = cdb_rd_value_q;
    cdb_regf_we_d  = cdb_regf_we_q;
    if (backend_flush) begin
      cdb_valid_d = '0;
    end else begin
      for (int j = 0; j < NUM_CDB; j++) begin
        if (slot_vld[j]) begin
          s = int'(slot_src[j]);
          cdb_rob_id_d[j*ROB_IDX +: ROB_IDX]   = bus.req_rob_id[s*ROB_IDX +: ROB_IDX];
          cdb_pd_d[j*PRF_IDX +: PRF_IDX]       = bus.req_pd[s*PRF_IDX +: PRF_IDX];
          cdb_rd_d[j*ARF_IDX +: ARF_IDX]       = bus.req_rd[s*ARF_IDX +: ARF_IDX];
          cdb_rd_value_d[j*32 +: 32]           = bus.req_rd_value[s*32 +: 32];
          cdb_regf_we_d[j]                     = bus.req_regf_we[s];
        end
      end
    end
  end

  always_comb begin : ptr_next
    rr_ptr_d = rr_ptr_q;
    if (backend_flush) begin
      rr_ptr_d = '0;
    end else if (|grant) begin
      rr_ptr_d = (last_win == PTR_W'(NUM_REQ - 1)) ? '0 : last_win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= '0;
      cdb_rob_id_q   <= '0;
      cdb_pd_q       <= '0;
      cdb_rd_q       <= '0;
      cdb_rd_value_q <= '0;
      cdb_regf_we_q  <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_rob_id_q   <= cdb_rob_id_d;
      cdb_pd_q       <= cdb_pd_d;
      cdb_rd_q       <= cdb_rd_d;
      cdb_rd_value_q <= cdb_rd_value_d;
      cdb_regf_we_q  <= cdb_regf_we_d;
    end
  end

  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_rob_id   = cdb_rob_id_q;
  assign bus.cdb_pd       = cdb_pd_q;
  assign bus.cdb_rd       = cdb_rd_q;
  assign bus.cdb_rd_value = cdb_rd_value_q;
  assign bus.cdb_regf_we  = cdb_regf_we_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant vectors checked at issue time,
// broadcasts checked by a monitor against a queue of expected slots.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int NC = 2;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic backend_flush = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  cdb_arbiter_if #(.NUM_REQ(NR), .NUM_CDB(NC), .ROB_IDX(RW), .PRF_IDX(PW), .ARF_IDX(AW)) bus ();

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .ROB_IDX(RW), .PRF_IDX(PW), .ARF_IDX(AW)) dut (
    .clk(clk),
    .rst(rst),
    .backend_flush(backend_flush),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [NC-1:0]   vld;
    logic [NC*RW-1:0] rob;
    logic [NC*PW-1:0] pd;
    logic [NC*AW-1:0] rd;
    logic [NC*32-1:0] val;
    logic [NC-1:0]   we;
  } exp_t;
  exp_t exp_q[$];

  logic [RW-1:0] p_rob [NR];
  logic [PW-1:0] p_pd  [NR];
  logic [AW-1:0] p_rd  [NR];
  logic [31:0]   p_val [NR];
  logic          p_we  [NR];
  int            seq   [NR];

  task automatic gen_pay(input int i);
    p_rob[i] = RW'((i * 7 + seq[i] * 3 + 1) % 32);
    p_pd[i]  = PW'((i * 11 + seq[i] * 5 + 2) % 64);
    p_rd[i]  = AW'((i * 3 + seq[i] + 4) % 32);
    p_val[i] = 32'h1000_0000 * (i + 1) + 32'(seq[i]);
    p_we[i]  = 1'((i + seq[i]) % 2);
  endtask

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      bus.req_rob_id[i*RW +: RW]  = p_rob[i];
      bus.req_pd[i*PW +: PW]      = p_pd[i];
      bus.req_rd[i*AW +: AW]      = p_rd[i];
      bus.req_rd_value[i*32 +: 32] = p_val[i];
      bus.req_regf_we[i]          = p_we[i];
    end
  endtask

  // Drive one cycle, check the grant vector, and queue the broadcast expected next cycle.
  task automatic step(input logic [NR-1:0] vld, input logic r, input logic fl,
                      input logic [NR-1:0] exp_rdy, input int s0, input int s1,
                      input string name);
    exp_t e;
    int src [NC];
    @(negedge clk);
    rst = r;
    backend_flush = fl;
    bus.req_valid = vld;
    pack();
    #1;
    n_cmp++;
    if (bus.req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s req_ready got %b want %b", name, bus.req_ready, exp_rdy);
    end
    $display("cyc %0d %s: valid=%b flush=%b rst=%b ready=%b", cyc, name, vld, fl, r, bus.req_ready);
    src[0] = s0;
    src[1] = s1;
    if (s0 >= 0) begin
      e.cyc = cyc + 1;
      e.vld = '0;
      e.rob = '0; e.pd = '0; e.rd = '0; e.val = '0; e.we = '0;
      for (int k = 0; k < NC; k++) begin
        if (src[k] >= 0) begin
          e.vld[k]          = 1'b1;
          e.rob[k*RW +: RW] = p_rob[src[k]];
          e.pd[k*PW +: PW]  = p_pd[src[k]];
          e.rd[k*AW +: AW]  = p_rd[src[k]];
          e.val[k*32 +: 32] = p_val[src[k]];
          e.we[k]           = p_we[src[k]];
        end
      end
      exp_q.push_back(e);
    end
    for (int i = 0; i < NR; i++) begin
      if (vld[i] && exp_rdy[i] && !fl && !r) begin
        seq[i]++;
        gen_pay(i);
      end
    end
  endtask

  // Monitor: compare whatever the CDB shows against the expectation for this cycle.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missed_bcast expected at cyc %0d got nothing by cyc %0d", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      logic ok;
      e = exp_q.pop_front();
      ok = (bus.cdb_valid === e.vld);
      for (int k = 0; k < NC; k++) begin
        if (e.vld[k]) begin
          if (bus.cdb_rob_id[k*RW +: RW] !== e.rob[k*RW +: RW]) ok = 1'b0;
          if (bus.cdb_pd[k*PW +: PW] !== e.pd[k*PW +: PW]) ok = 1'b0;
          if (bus.cdb_rd[k*AW +: AW] !== e.rd[k*AW +: AW]) ok = 1'b0;
          if (bus.cdb_rd_value[k*32 +: 32] !== e.val[k*32 +: 32]) ok = 1'b0;
          if (bus.cdb_regf_we[k] !== e.we[k]) ok = 1'b0;
        end
      end
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL bcast cyc %0d got v=%b rob=%h pd=%h rd=%h val=%h we=%b want v=%b rob=%h pd=%h rd=%h val=%h we=%b",
                 cyc, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_pd, bus.cdb_rd, bus.cdb_rd_value, bus.cdb_regf_we,
                 e.vld, e.rob, e.pd, e.rd, e.val, e.we);
      end else begin
        $display("cyc %0d bcast v=%b rob=%h val=%h", cyc, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_rd_value);
      end
    end else if (bus.cdb_valid !== '0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_bcast cyc %0d got v=%b want 00", cyc, bus.cdb_valid);
    end
  end

  task automatic check_cdb_zero(input string name);
    n_cmp++;
    if (bus.cdb_valid !== '0 || bus.cdb_rob_id !== '0 || bus.cdb_pd !== '0 ||
        bus.cdb_rd !== '0 || bus.cdb_rd_value !== '0 || bus.cdb_regf_we !== '0) begin
      n_fail++;
      $display("FAIL %s cdb got v=%b rob=%h pd=%h rd=%h val=%h we=%b want all 0", name,
               bus.cdb_valid, bus.cdb_rob_id, bus.cdb_pd, bus.cdb_rd, bus.cdb_rd_value, bus.cdb_regf_we);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      seq[i] = 0;
      gen_pay(i);
    end
    pack();

    // reset with all requesters valid
    step(4'b1111, 1'b1, 1'b0, 4'b0000, -1, -1, "reset_hold0");
    step(4'b1111, 1'b1, 1'b0, 4'b0000, -1, -1, "reset_hold1");
    check_cdb_zero("reset_state");

    // all valid for 4 cycles: {0,1},{2,3},{0,1},{2,3}
    step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1, "all_valid_c0");
    step(4'b1111, 1'b0, 1'b0, 4'b1100, 2, 3, "all_valid_c1");
    step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1, "all_valid_c2");
    step(4'b1111, 1'b0, 1'b0, 4'b1100, 2, 3, "all_valid_c3");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, "idle0");

    // single requester 2 with fixed payload; rr_ptr=0 -> 3
    p_rob[2] = 5'd5; p_pd[2] = 6'd17; p_val[2] = 32'hDEADBEEF; p_we[2] = 1'b1;
    step(4'b0100, 1'b0, 1'b0, 4'b0100, 2, -1, "single_req2");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, "idle1");

    // wrap: rr_ptr=3 -> req3 slot0, req0 slot1, rr_ptr=1
    step(4'b1001, 1'b0, 1'b0, 4'b1001, 3, 0, "wrap");

    // backpressure: scan from 1 grants 1,2; req0 waits, then wins unchanged
    step(4'b0111, 1'b0, 1'b0, 4'b0110, 1, 2, "bp_first");
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 0, -1, "bp_held");

    // flush: grant req1 (rr_ptr -> 2), flush next cycle, then pointer back at 0
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1, -1, "flush_pre");
    step(4'b0100, 1'b0, 1'b1, 4'b0000, -1, -1, "flush");
    step(4'b1110, 1'b0, 1'b0, 4'b0110, 1, 2, "post_flush");

    // mid-run reset clears latched payload and pointer (rr_ptr was 3)
    step(4'b0000, 1'b1, 1'b0, 4'b0000, -1, -1, "reset_mid");
    @(negedge clk);
    check_cdb_zero("reset_mid_state");
    step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1, "after_reset");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, "drain0");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, "drain1");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares NUM_CDB common data bus broadcast slots among NUM_REQ backend functional-unit writeback requesters (int, intm, branch, lsu, …).
- Sits between the FU writeback outputs and the CDB consumers: rat, rob, prf and the reservation stations.
- Replaces the fixed one-FU-per-CDB binding so FU count can exceed CDB count.
- Rotating-priority grant; registered broadcast with 1-cycle latency; starvation-free.

Parameters:
- NUM_REQ, 4, number of writeback requesters (≥2).
- NUM_CDB, 2, number of broadcast slots (1 ≤ NUM_CDB ≤ NUM_REQ).
- ROB_IDX, 5, ROB index width.
- PRF_IDX, 6, physical register index width.
- ARF_IDX, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- backend_flush  in  1  pipeline flush; kills pending and in-flight broadcasts.
- req_valid  in  NUM_REQ  requester i has a result.
- req_ready  out  NUM_REQ  requester i granted this cycle.
- req_rob_id  in  NUM_REQ*ROB_IDX  packed per requester.
- req_pd  in  NUM_REQ*PRF_IDX  destination physical register.
- req_rd  in  NUM_REQ*ARF_IDX  destination architectural register.
- req_rd_value  in  NUM_REQ*32  result data.
- req_regf_we  in  NUM_REQ  result writes the register file.
- cdb_valid  out  NUM_CDB  slot k broadcasting.
- cdb_rob_id, cdb_pd, cdb_rd, cdb_rd_value, cdb_regf_we  out  NUM_CDB*(field width)  registered broadcast payload.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cdb_valid, cdb_rob_id, cdb_pd, cdb_rd, cdb_rd_value and cdb_regf_we all become 0.
  - rr_ptr becomes 0.
  - req_ready stays 0 while rst is high.
- Handshake is valid/ready. A transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid and rr_ptr.
  - Requesters must not make req_valid depend on req_ready.
  - While req_valid[i] && !req_ready[i], requester i holds its payload stable.
- Grant computation (combinational, each cycle):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first NUM_CDB indices with req_valid=1 are granted, up to NUM_CDB total.
  - The j-th winner in scan order is assigned to slot j.
  - Ungranted slots are idle.
- Broadcast (registered):
  - At the clk edge, cdb_valid[j] is set to 1 if slot j has a winner, else 0.
  - The winner's payload is copied into slot j's output fields.
  - Latency: the cycle after the handshake. Each broadcast lasts exactly 1 cycle.
  - Idle slot payload fields hold their previous values; consumers qualify them with cdb_valid.
- Pointer update:
  - If any grant occurred, rr_ptr becomes (index of last winner + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap: rr_ptr=NUM_REQ-1 with winner NUM_REQ-1 gives rr_ptr=0.
- Fairness: a requester holding req_valid=1 is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- All valid, NUM_CDB=NUM_REQ: every requester is granted every cycle; no backpressure.
- No requests: no grants, all cdb_valid go to 0 next cycle, rr_ptr holds.
- backend_flush=1 in a cycle:
  - req_ready is forced to 0 in that cycle.
  - At the edge, cdb_valid becomes all 0, so a broadcast latched in the previous cycle is still visible in the flush cycle.
  - rr_ptr resets to 0.
  - Nothing granted during flush is ever broadcast.
- rst and backend_flush together: rst behaviour applies.
- The block does not check that rob_id is unique across slots; requesters are responsible for that.

Test Plan:
- Reset with all req_valid=1 → req_ready=0 while rst=1. After rst drops, the first cycle grants req 0→slot0 and req 1→slot1. Next cycle: cdb_valid=2'b11, rr_ptr=2.
- Single requester: req 2 valid with rob_id=5, pd=17, value=0xDEADBEEF, regf_we=1 → req_ready=4'b0100 same cycle. Next cycle: cdb_valid=2'b01 and slot0 carries those values. Following cycle: cdb_valid=0.
- All 4 valid, held for 4 cycles → grants {0,1},{2,3},{0,1},{2,3}. No requester waits more than 2 cycles. rr_ptr sequence 2,0,2,0.
- Wrap: rr_ptr=3, req 3 and req 0 valid → req 3→slot0, req 0→slot1; rr_ptr becomes 1.
- Flush: grant req 1 in cycle N, assert backend_flush in cycle N+1 with req 2 valid → cdb_valid slot0=1 in N+1. req_ready=0 in N+1. cdb_valid=0 in N+2 and rr_ptr=0.
- Backpressure hold: 3 valid requesters with payloads held stable → the ungranted one is granted the following cycle with its payload unchanged on the CDB.
